// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation codes, FSM states, constants and small operand helpers.
package muldiv_pkg;

    localparam int          ITER      = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // bit2 = divide family, bit1 = high word / remainder, bit0 = unsigned
    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_MULU = 3'd1,
        OP_MUH  = 3'd2,
        OP_MUHU = 3'd3,
        OP_DIV  = 3'd4,
        OP_DIVU = 3'd5,
        OP_MOD  = 3'd6,
        OP_MODU = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Full 64-bit product; sign extension makes the low 64 bits exact for signed ops
    function automatic logic [63:0] mul_full(input op_e op, input logic [31:0] x,
                                             input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = op_is_signed(op) ? {{32{x[31]}}, x} : {32'd0, x};
        ye = op_is_signed(op) ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: MSB-first shift-add for multiply,
// restoring shift-subtract for divide ({remainder, quotient} in the accumulator).
module muldiv_step (
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    input  logic        a_bit,
    input  logic        is_div,
    output logic [63:0] acc_next
);

    logic [32:0] trial_s;
    logic [32:0] diff_s;

    // Next accumulator for one multiply or divide iteration
    always_comb begin
        trial_s  = {acc[63:32], a_bit};
        diff_s   = trial_s - {1'b0, opnd};
        acc_next = 64'd0;
        if (is_div) begin
            // remainder < divisor always, so diff_s[32] is a clean borrow flag
            if (!diff_s[32]) begin
                acc_next = {diff_s[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {trial_s[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {acc[62:0], 1'b0} + (a_bit ? {32'd0, opnd} : 64'd0);
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer (FSM, operand/sign registers, result mux).
// Optional MULDIV_FAST_MUL_EN: multiply ops bypass the iterative loop (done at N+2).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_zero
);

`ifdef MULDIV_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
`else
    localparam logic FAST_MUL = 1'b0;
`endif

    state_e          state_r;
    op_e             op_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    logic [63:0]     acc_r;
    logic [4:0]      cnt_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            busy_r;
    logic            done_r;
    logic            div_zero_r;
    logic [31:0]     result_r;

    logic [63:0]     acc_next_s;
    logic [63:0]     prod_s;
    logic [31:0]     quot_s;
    logic [31:0]     rem_s;
    logic [31:0]     fix_s;
    op_e             op_in_s;

    assign op_in_s = op_e'(op);

    // a_r doubles as the shift register that feeds one operand bit per step
    muldiv_step u_step (
        .acc      (acc_r),
        .opnd     (b_r),
        .a_bit    (a_r[31]),
        .is_div   (op_is_div(op_r)),
        .acc_next (acc_next_s)
    );

    // Sign correction and output selection, registered on the edge into DONE
    always_comb begin
        prod_s = neg_q_r ? (64'd0 - acc_r) : acc_r;
        quot_s = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        rem_s  = neg_r_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        case (op_r)
            OP_MUL, OP_MULU: fix_s = prod_s[31:0];
            OP_MUH, OP_MUHU: fix_s = prod_s[63:32];
            OP_DIV, OP_DIVU: fix_s = quot_s;
            OP_MOD, OP_MODU: fix_s = rem_s;
            default:         fix_s = 32'd0;
        endcase
    end

    // Sequencer FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_MUL;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            acc_r      <= 64'd0;
            cnt_r      <= 5'd0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            result_r   <= 32'd0;
        end else if (flush && (state_r != ST_IDLE)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r   <= op_in_s;
                        a_r    <= a;
                        b_r    <= b;
                        busy_r <= 1'b1;
                        if (op_is_div(op_in_s) && (b == 32'd0)) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                            result_r   <= op_is_rem(op_in_s) ? a : DIV0_QUOT;
                        end else if (FAST_MUL && !op_is_div(op_in_s)) begin
                            acc_r   <= mul_full(op_in_s, a, b);
                            neg_q_r <= 1'b0;
                            neg_r_r <= 1'b0;
                            state_r <= ST_FIXUP;
                        end else begin
                            state_r <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    if (op_is_signed(op_r)) begin
                        a_r <= mag32(a_r);
                        b_r <= mag32(b_r);
                    end
                    neg_q_r <= op_is_signed(op_r) & (a_r[31] ^ b_r[31]);
                    neg_r_r <= op_is_signed(op_r) & a_r[31];
                    acc_r   <= 64'd0;
                    cnt_r   <= 5'd0;
                    state_r <= ST_CALC;
                end
                ST_CALC: begin
                    acc_r <= acc_next_s;
                    a_r   <= {a_r[30:0], 1'b0};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(ITER - 1)) begin
                        state_r <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    result_r   <= fix_s;
                    div_zero_r <= 1'b0;
                    done_r     <= 1'b1;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes model results, a monitor checks
// each done pulse (value, div_zero, cycle) and busy on every cycle.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_zero;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_from = 1;
    int          busy_to = 0;
    logic [31:0] last_res = 32'd0;

    muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic dz);
        longint      sx, sy, t;
        logic [63:0] pu, ps;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        pu = {32'd0, x} * {32'd0, y};
        dz = 1'b0;
        r  = 32'd0;
        if (o == OP_MUL || o == OP_MULU) begin
            r = pu[31:0];
        end else if (o == OP_MUH) begin
            t = sx * sy; ps = t; r = ps[63:32];
        end else if (o == OP_MUHU) begin
            r = pu[63:32];
        end else if (y == 32'd0) begin
            dz = 1'b1;
            r  = (o == OP_MOD || o == OP_MODU) ? x : 32'hFFFF_FFFF;
        end else if (o == OP_DIV) begin
            t = sx / sy; ps = t; r = ps[31:0];
        end else if (o == OP_MOD) begin
            t = sx % sy; ps = t; r = ps[31:0];
        end else if (o == OP_DIVU) begin
            r = x / y;
        end else begin
            r = x % y;
        end
    endtask

    function automatic int latency(input logic [2:0] o, input logic [31:0] y);
        if (o[2] && y == 32'd0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 2;
`endif
        return 35;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
        logic [31:0] r;
        logic        dz;
        bit          ok;
        exp_t        e;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout at cycle %0d: busy=%0b, required 0", cyc, busy);
        end
        chk("result_hold", result, last_res);
        model(o, x, y, r, dz);
        n = cyc;
        e.res = r; e.dz = dz; e.cyc = n + latency(o, y);
        sb_q.push_back(e);
        busy_from = n + 1;
        busy_to   = n + latency(o, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: compare every done pulse against the scoreboard, busy every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from) && (cyc <= busy_to)});
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done at cycle %0d: result=0x%08h, none pending", cyc, result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    chk("done_cycle", cyc, e.cyc);
                    last_res = e.res;
                end
            end
        end
    end

    initial begin
        int          n;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, n);
        issue(OP_MOD,  32'hFFFF_FFF9, 32'd2, n);
        issue(OP_MUHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        issue(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        issue(OP_DIVU, 32'd123, 32'd0, n);
        issue(OP_MODU, 32'd123, 32'd0, n);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, n);
        issue(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, n);
        issue(OP_MUL,  32'd3, 32'd5, n);
        issue(OP_MUH,  32'h8000_0000, 32'h7FFF_FFFF, n);

        // flush mid-divide: no done, result kept, immediate restart
        issue(OP_DIVU, 32'd1000, 32'd7, n);
        wait_cycle(n + 10);
        flush = 1'b1;
        busy_to = cyc;
        void'(sb_q.pop_back());
        @(posedge clk);
        #1 flush = 1'b0;
        issue(OP_MODU, 32'd1000, 32'd7, n);

        // starts while busy and in the DONE cycle are dropped
        issue(OP_DIV, 32'd100, 32'hFFFF_FFFD, n);
        wait_cycle(n + 5);
        op = OP_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_cycle(n + 35);
        op = OP_DIVU; a = 32'd77; b = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
            issue(ro, ra, rb, n);
        end

        // reset mid-operation clears result
        issue(OP_MULU, 32'd12345, 32'd678, n);
        wait_cycle(n + 8);
        rst_n = 1'b0;
        busy_to = cyc;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result", result, 32'd0);
        rst_n = 1'b1;
        last_res = 32'd0;
        issue(OP_DIVU, 32'd50, 32'd6, n);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb_q.size());
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
